// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: accepts 16-bit instructions, drives the ALU opcode and
// operands from a 16x16 register file, then writes back the registered
// ALU result, latches flags or issues a one-cycle memory store.
// Ports:
//   clock, reset                                     clock / async active-high reset
//   instr_valid, instr, instr_ready                  instruction handshake
//   alu_opcode, alu_rdataA, alu_rdataB               to ALU
//   alu_result, alu_psr                              from ALU (registered in ALU)
//   flags                                            architectural flags
//   mem_we, mem_addr, mem_wdata                      store port
//   illegal, busy                                    status
//   dbg_addr, dbg_data                               register-file debug read
module alu_issue_ctrl #(
    parameter int         NREGS     = 16,
    parameter logic [4:0] FLAG_MASK = 5'b11110
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        instr_valid,
    input  logic [15:0] instr,
    output logic        instr_ready,
    output logic [7:0]  alu_opcode,
    output logic [15:0] alu_rdataA,
    output logic [15:0] alu_rdataB,
    input  logic [15:0] alu_result,
    input  logic [4:0]  alu_psr,
    output logic [4:0]  flags,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        illegal,
    output logic        busy,
    input  logic [3:0]  dbg_addr,
    output logic [15:0] dbg_data
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WB
    } state_t;

    state_t      r_state;
    logic [15:0] r_regs [NREGS];
    logic [15:0] r_instr;
    logic [7:0]  r_opcode;
    logic [15:0] r_a;
    logic [15:0] r_b;
    logic [4:0]  r_flags;
    logic        r_mem_we;
    logic [15:0] r_mem_addr;
    logic [15:0] r_mem_wdata;
    logic        r_illegal;

    // Decode of the held instruction; stable through ISSUE and WB.
    logic [3:0] w_cls;
    logic [3:0] w_ext;
    logic [3:0] w_rd;
    logic [3:0] w_rs;
    logic       w_alu0;
    logic       w_cmp;
    logic       w_wr;
    logic       w_flg;
    logic       w_st;
    logic       w_ill;
    logic       w_in_lui;

    assign w_cls  = r_instr[15:12];
    assign w_ext  = r_instr[7:4];
    assign w_rd   = r_instr[11:8];
    assign w_rs   = r_instr[3:0];
    assign w_alu0 = (w_cls == 4'h0) &&
                    (w_ext inside {4'h1, 4'h2, 4'h3, 4'h5,
                                   4'h6, 4'h9, 4'hD});
    assign w_cmp  = (w_cls == 4'h0) && (w_ext == 4'hB);
    assign w_wr   = w_alu0 || (w_cls == 4'h8) || (w_cls == 4'hF);
    assign w_flg  = (w_cls == 4'h0) && ((w_ext == 4'h5) || w_cmp);
    assign w_st   = (w_cls == 4'h4) && (w_ext == 4'h4);
    assign w_ill  = !(w_wr || w_cmp || w_st);

    assign w_in_lui = (instr[15:12] == 4'hF);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
            r_instr     <= '0;
            r_opcode    <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_flags     <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_illegal   <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (instr_valid) begin
                        // Operands are sampled at accept so they are
                        // already on the ALU inputs throughout ISSUE.
                        r_instr <= instr;
                        r_a     <= r_regs[instr[11:8]];
                        if (w_in_lui) begin
                            r_opcode <= 8'hF0;
                            r_b      <= {8'h00, instr[7:0]};
                        end else begin
                            r_opcode <= {instr[15:12], instr[7:4]};
                            r_b      <= r_regs[instr[3:0]];
                        end
                        r_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Strobes are registered here so they are high
                    // exactly during WB.
                    r_mem_we  <= w_st;
                    r_illegal <= w_ill;
                    if (w_st) begin
                        r_mem_addr <= r_regs[w_rs];
                    end
                    r_state <= WB;
                end
                WB: begin
                    if (w_wr) begin
                        r_regs[w_rd] <= alu_result;
                    end
                    if (w_flg) begin
                        r_flags <= (r_flags & ~FLAG_MASK) |
                                   (alu_psr & FLAG_MASK);
                    end
                    if (r_mem_we) begin
                        r_mem_wdata <= alu_result;
                    end
                    r_mem_we  <= 1'b0;
                    r_illegal <= 1'b0;
                    r_state   <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign instr_ready = (r_state == IDLE);
    assign busy        = (r_state != IDLE);
    assign alu_opcode  = r_opcode;
    assign alu_rdataA  = r_a;
    assign alu_rdataB  = r_b;
    assign flags       = r_flags;
    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign illegal     = r_illegal;
    assign dbg_data    = r_regs[dbg_addr];

    // Store data only exists on alu_result during WB; pass it through
    // then, and hold the captured copy afterwards.
    assign mem_wdata = ((r_state == WB) && r_mem_we) ? alu_result
                                                     : r_mem_wdata;

endmodule
